wide_add_sequencer: RTL and testbench

//  Multi-cycle wide adder: one N-bit han_carlson prefix adder is reused WORDS times to add

---
 rtl/wide_add_pkg.sv | 12 +
 rtl/han_carlson.sv | 47 ++++
 rtl/wide_add_word_slice.sv | 29 ++
 rtl/wide_add_sequencer.sv | 106 ++++++++++
 tb/tb_wide_add_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the wide add sequencer.
package wide_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} wa_state_t;

  function automatic int idx_bits(input int words);
    int b;
    b = $clog2(words);
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/han_carlson.sv
// Han-Carlson parallel prefix carry network: K Brent-Kung levels around a sparse Kogge-Stone core.
// Position 0 carries the incoming carry as its generate; c[i] is the carry out of bit i.
module han_carlson #(
  parameter int N = 32,
  parameter int K = 1
) (
  input  logic [N:0] g,
  input  logic [N:1] p,
  output logic [N:0] c
);

  always_comb begin : pfx
    logic [N:0] gg;
    logic [N:0] pp;
    gg = g;
    pp = {p, 1'b0};
    // Up-sweep: positions 2^l-1 (mod 2^l) gather spans of 2^l.
    for (int l = 1; l <= K; l++) begin
      for (int j = 0; j <= N; j++) begin
        if ((j % (2 << (l - 1))) == (2 << (l - 1)) - 1 && j >= (1 << (l - 1))) begin
          gg[j] = gg[j] | (pp[j] & gg[j - (1 << (l - 1))]);
          pp[j] = pp[j] & pp[j - (1 << (l - 1))];
        end
      end
    end
    // Kogge-Stone on the sparse set; descending j keeps j-d at its previous-level value.
    for (int d = (1 << K); d <= N; d = d * 2) begin
      for (int j = N; j >= 0; j--) begin
        if ((j % (1 << K)) == (1 << K) - 1 && j >= d) begin
          gg[j] = gg[j] | (pp[j] & gg[j - d]);
          pp[j] = pp[j] & pp[j - d];
        end
      end
    end
    // Down-sweep fills the positions skipped above.
    for (int l = K; l >= 1; l--) begin
      for (int j = 0; j <= N; j++) begin
        if ((j % (2 << (l - 1))) == (1 << (l - 1)) - 1 && j > (1 << (l - 1))) begin
          gg[j] = gg[j] | (pp[j] & gg[j - (1 << (l - 1))]);
          pp[j] = pp[j] & pp[j - (1 << (l - 1))];
        end
      end
    end
    c = gg;
  end

endmodule

// File: rtl/wide_add_word_slice.sv
// Combinational N-bit word adder slice built on the shared han_carlson prefix network.
module add_word_slice #(
  parameter int N = 32,
  parameter int K = 1
) (
  input  logic [N-1:0] a_w,
  input  logic [N-1:0] b_w,
  input  logic         ci,
  output logic [N-1:0] s_w,
  output logic         co
);

  logic [N:0] g;
  logic [N:1] p;
  logic [N:0] c;

  assign g = {a_w & b_w, ci};
  assign p = a_w ^ b_w;

  han_carlson #(.N(N), .K(K)) u_hc (
    .g (g),
    .p (p),
    .c (c)
  );

  assign s_w = p ^ c[N-1:0];
  assign co  = c[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// Word-serial WORDS*N-bit adder with valid/ready on both sides, one word per clock.
// Optional subtract mode (extra "sub" port) is enabled by defining WIDE_ADD_SEQ_SUB_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding word idx, carry held between words
// DONE  | result presented, out_valid high until taken
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int N     = 32,
  parameter int K     = 1,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout
);

  localparam int W  = N * WORDS;
  localparam int IW = idx_bits(WORDS);

  wa_state_t       state_q, state_d;
  logic [W-1:0]    a_q, b_q, b_in;
  logic [IW-1:0]   idx;
  logic            carry, c_in, last;
  logic [N-1:0]    a_w, b_w, s_w;
  logic            co;

  // Subtraction is folded in at capture time: B stored inverted, carry-in forced to 1.
`ifdef WIDE_ADD_SEQ_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign a_w       = a_q[int'(idx)*N +: N];
  assign b_w       = b_q[int'(idx)*N +: N];
  assign last      = (idx == IW'(WORDS - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  add_word_slice #(.N(N), .K(K)) u_slice (
    .a_w (a_w),
    .b_w (b_w),
    .ci  (carry),
    .s_w (s_w),
    .co  (co)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b_in;
          carry <= c_in;
          idx   <= '0;
        end
        RUN: begin
          sum[int'(idx)*N +: N] <= s_w;
          carry <= co;
          if (last) cout <= co;
          else      idx  <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench: directed vectors, backpressure/reset sequences, WORDS=1 instance,
// and randomized handshakes against a plain-arithmetic golden model.
module tb_wide_add_sequencer;

  localparam int N = 8, K = 1, WORDS = 4, W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 0, in_ready, cin = 0, out_valid, out_ready = 0, cout, sub_i = 0;
  logic [W-1:0] a = '0, b = '0, sum;

  logic         in_valid1 = 0, in_ready1, cin1 = 0, out_valid1, out_ready1 = 0, cout1;
  logic [15:0]  a1 = '0, b1 = '0, sum1;

  wide_add_sequencer #(.N(N), .K(K), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef WIDE_ADD_SEQ_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  wide_add_sequencer #(.N(16), .K(1), .WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef WIDE_ADD_SEQ_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns result, cout and latency.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, output logic [W-1:0] rs, output logic rc,
                        output int lat);
    a = ta; b = tb_; cin = tc; sub_i = ts; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; a = $urandom; b = $urandom; cin = 1'($urandom); sub_i = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] rs, hold_s;
    logic         rc, hold_c;
    int           lat;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[1] = '{32'h12345678, 32'h0F0F0F0F, 1'b1, 32'h21436588, 1'b0};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
    vecs[6] = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1};

    #12;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, rs, rc, lat);
      check($sformatf("vec%0d sum", i), rs, vecs[i].s);
      check($sformatf("vec%0d cout", i), rc, vecs[i].co);
      check($sformatf("vec%0d latency", i), lat, WORDS);
      check($sformatf("vec%0d idle in_ready", i), in_ready, 1);
      check($sformatf("vec%0d idle out_valid", i), out_valid, 0);
    end

    // Backpressure: result held, new operands refused while DONE.
    a = 32'h01020304; b = 32'h10203040; cin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("bp latency", lat, WORDS);
    hold_s = sum; hold_c = cout;
    check("bp sum", hold_s, 32'h11223344);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; a = 32'hDEADBEEF; b = 32'h01010101; cin = 1;
      @(posedge clk); #1;
      check($sformatf("bp%0d sum stable", i), sum, hold_s);
      check($sformatf("bp%0d cout stable", i), cout, hold_c);
      check($sformatf("bp%0d in_ready", i), in_ready, 0);
      check($sformatf("bp%0d out_valid", i), out_valid, 1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    check("bp release in_ready", in_ready, 1);
    check("bp release out_valid", out_valid, 0);
    in_valid = 0; out_ready = 0;
    run_op(32'h00000100, 32'h00000200, 1'b0, 1'b0, rs, rc, lat);
    check("after bp sum", rs, 32'h00000300);

    // Reset on the second RUN edge.
    a = 32'h11111111; b = 32'h11111111; cin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("rst run out_valid", out_valid, 0);
    check("rst run sum", sum, 0);
    check("rst run cout", cout, 0);
    check("rst run in_ready", in_ready, 1);
    #2 rst_n = 1;
    @(posedge clk); #1;
    run_op(32'h1, 32'h2, 1'b0, 1'b0, rs, rc, lat);
    check("post rst sum", rs, 32'h3);
    check("post rst cout", rc, 0);
    check("post rst latency", lat, WORDS);

    // Single-word instance.
    a1 = 16'hFFFF; b1 = 16'hFFFF; cin1 = 1; in_valid1 = 1;
    @(posedge clk); #1;
    in_valid1 = 0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("w1 latency", lat, 1);
    check("w1 sum", sum1, 16'hFFFF);
    check("w1 cout", cout1, 1);
    out_ready1 = 1;
    @(posedge clk); #1;
    out_ready1 = 0;
    check("w1 idle in_ready", in_ready1, 1);

`ifdef WIDE_ADD_SEQ_SUB_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1, rs, rc, lat);
    check("sub 5-7 sum", rs, 32'hFFFFFFFE);
    check("sub 5-7 cout", rc, 0);
    run_op(32'd7, 32'd5, 1'b1, 1'b1, rs, rc, lat);
    check("sub 7-5 sum", rs, 32'd2);
    check("sub 7-5 cout", rc, 1);
`endif

    // Randomized handshakes against a W+1-bit arithmetic model.
    begin
      logic [W:0] exp_q[$];
      int         acc_q[$];
      logic [W:0] t, e;
      logic [W-1:0] bb;
      int  cyc = 0, done_ops = 0;
      logic prev_ov, acc, take;
      prev_ov = out_valid;
      while (done_ops < 2000 && cyc < 60000) begin
        in_valid  = ($urandom % 3) != 0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
`ifdef WIDE_ADD_SEQ_SUB_EN
        sub_i = 1'($urandom);
`endif
        out_ready = 1'($urandom);
        acc  = in_valid && in_ready;
        take = out_valid && out_ready;
        if (take) begin
          check("rand result expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rand sum", sum, e[W-1:0]);
            check("rand cout", cout, e[W]);
          end
          done_ops++;
        end
        if (acc) begin
          bb = sub_i ? ~b : b;
          t  = {1'b0, a} + {1'b0, bb} + (W+1)'(sub_i ? 1'b1 : cin);
          exp_q.push_back(t);
          acc_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        cyc++;
        if (out_valid && !prev_ov) begin
          check("rand latency known", acc_q.size() > 0, 1);
          if (acc_q.size() > 0) check("rand latency", cyc - acc_q.pop_front(), WORDS);
        end
        prev_ov = out_valid;
      end
      in_valid = 0; out_ready = 0;
      check("rand ops completed", done_ops, 2000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
